// File: rtl/second_int_if.sv
// Handshake and data bundle for the second_int double integrator.
interface second_int_if #(
  parameter int DATA_W = 12
);
  logic                     clr;
  logic                     en_second_int;
  logic signed [DATA_W:0]   second_dif_data;
  logic        [DATA_W-1:0] int_data;
  logic                     second_int_finish;
  logic                     busy;
  logic                     ovf;

  modport master (
    output clr, en_second_int, second_dif_data,
    input  int_data, second_int_finish, busy, ovf
  );

  modport slave (
    input  clr, en_second_int, second_dif_data,
    output int_data, second_int_finish, busy, ovf
  );
endinterface

// File: rtl/second_int.sv
// Double integrator rebuilding 12-bit samples from signed second differences.
// Optional build macro SECOND_INT_SAT_EN clamps the output instead of wrapping it.
module second_int #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = DATA_W + 4   // must be at least DATA_W + 2
) (
  input  logic        clk,
  input  logic        rst_n,
  second_int_if.slave bus
);

  typedef enum logic [3:0] {
    WAIT   = 4'b0001,
    VEL    = 4'b0010,
    POS    = 4'b0100,
    FINISH = 4'b1000
  } state_t;

  localparam logic signed [ACC_W-1:0] POS_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] VEL_MIN = {{(ACC_W-DATA_W){1'b1}}, {DATA_W{1'b0}}};

  function automatic logic pos_out_of_range(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] || (v > POS_MAX);
  endfunction

  function automatic logic vel_out_of_range(input logic signed [ACC_W-1:0] v);
    return (v < VEL_MIN) || (v > POS_MAX);
  endfunction

  function automatic logic [DATA_W-1:0] out_map(input logic signed [ACC_W-1:0] v);
`ifdef SECOND_INT_SAT_EN
    if (v[ACC_W-1])
      return '0;
    else if (v > POS_MAX)
      return '1;
    else
      return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  state_t                   state;
  logic signed [DATA_W:0]   din_p0;
  logic signed [ACC_W-1:0]  vel_acc;
  logic signed [ACC_W-1:0]  pos_acc;
  logic signed [ACC_W-1:0]  vel_nxt;
  logic signed [ACC_W-1:0]  pos_nxt;

  assign vel_nxt = vel_acc + {{(ACC_W-DATA_W-1){din_p0[DATA_W]}}, din_p0};
  // POS runs after VEL, so vel_acc already holds the freshly updated velocity here
  assign pos_nxt = pos_acc + vel_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= WAIT;
      din_p0                <= '0;
      vel_acc               <= '0;
      pos_acc               <= '0;
      bus.int_data          <= '0;
      bus.second_int_finish <= 1'b0;
      bus.busy              <= 1'b0;
      bus.ovf               <= 1'b0;
    end else if (bus.clr) begin
      state                 <= WAIT;
      din_p0                <= '0;
      vel_acc               <= '0;
      pos_acc               <= '0;
      bus.int_data          <= '0;
      bus.second_int_finish <= 1'b0;
      bus.busy              <= 1'b0;
      bus.ovf               <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          bus.second_int_finish <= 1'b0;
          if (bus.en_second_int) begin
            din_p0   <= bus.second_dif_data;
            state    <= VEL;
            bus.busy <= 1'b1;
          end
        end
        // stage 1: velocity accumulator
        VEL: begin
          vel_acc <= vel_nxt;
          if (vel_out_of_range(vel_nxt))
            bus.ovf <= 1'b1;
          state <= POS;
        end
        // stage 2: position accumulator and output register
        POS: begin
          pos_acc               <= pos_nxt;
          bus.int_data          <= out_map(pos_nxt);
          bus.second_int_finish <= 1'b1;
          if (pos_out_of_range(pos_nxt))
            bus.ovf <= 1'b1;
          state <= FINISH;
        end
        FINISH: begin
          bus.second_int_finish <= 1'b0;
          bus.busy              <= 1'b0;
          state                 <= WAIT;
        end
        default: begin
          bus.second_int_finish <= 1'b0;
          bus.busy              <= 1'b0;
          state                 <= WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_second_int.sv
// Randomised and directed bench for second_int against a closed-form double-sum model.
module tb_second_int;
  localparam int DATA_W = 12;
  localparam int ACC_W  = DATA_W + 4;
  localparam int IN_W   = DATA_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  second_int_if #(.DATA_W(DATA_W)) bus ();

  second_int #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap(input longint v);
    longint m;
    longint span;
    span = longint'(1) << ACC_W;
    m = v % span;
    if (m < 0) m += span;
    if (m >= span / 2) m -= span;
    return m;
  endfunction

  function automatic longint omap(input longint p);
    longint top;
    top = (longint'(1) << DATA_W) - 1;
`ifdef SECOND_INT_SAT_EN
    if (p < 0) return 0;
    if (p > top) return top;
    return p;
`else
    return p & top;
`endif
  endfunction

  // Model: samples since last clear; velocity is their sum and position
  // is the weighted sum of all samples, both reduced modulo 2^ACC_W.
  longint samples[$];
  int     cyc = 0;
  int     acc_cyc = -1000;
  longint exp_int = 0;
  logic   exp_fin = 1'b0;
  logic   exp_busy = 1'b0;
  logic   exp_ovf = 1'b0;

  always @(negedge clk) begin
    longint vel;
    longint pos;
    int n;
    cyc++;
    if (!rst_n || bus.clr) begin
      samples.delete();
      acc_cyc = -1000;
      exp_int = 0;
      exp_fin = 1'b0;
      exp_ovf = 1'b0;
    end else begin
      exp_fin = 1'b0;
      if (bus.en_second_int && (cyc - acc_cyc) >= 4) begin
        samples.push_back(longint'(bus.second_dif_data));
        acc_cyc = cyc;
      end else if (cyc == acc_cyc + 1) begin
        vel = 0;
        foreach (samples[i]) vel += samples[i];
        vel = wrap(vel);
        if (vel < -(longint'(1) << DATA_W) || vel > (longint'(1) << DATA_W) - 1) exp_ovf = 1'b1;
      end else if (cyc == acc_cyc + 2) begin
        n = samples.size();
        pos = 0;
        foreach (samples[i]) pos += longint'(n - i) * samples[i];
        pos = wrap(pos);
        if (pos < 0 || pos > (longint'(1) << DATA_W) - 1) exp_ovf = 1'b1;
        exp_int = omap(pos);
        exp_fin = 1'b1;
      end
    end
    exp_busy = ((cyc - acc_cyc) <= 2);
    chk("int_data", longint'(bus.int_data), exp_int);
    chk("finish", longint'(bus.second_int_finish), longint'(exp_fin));
    chk("busy", longint'(bus.busy), longint'(exp_busy));
    chk("ovf", longint'(bus.ovf), longint'(exp_ovf));
  end

  task automatic send(input int d, input longint lit, input string name);
    bit seen;
    @(negedge clk); #1;
    bus.en_second_int   = 1'b1;
    bus.second_dif_data = IN_W'(d);
    @(negedge clk); #1;
    bus.en_second_int   = 1'b0;
    bus.second_dif_data = IN_W'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (bus.second_int_finish) seen = 1'b1;
    end
    if (!seen) chk({name, " timeout"}, 0, 1);
    else       chk(name, longint'(bus.int_data), lit);
  endtask

  task automatic do_clr();
    @(negedge clk); #1;
    bus.clr = 1'b1;
    @(negedge clk); #1;
    bus.clr = 1'b0;
  endtask

  initial begin
    int nfin;
    longint got;
    bus.clr             = 1'b0;
    bus.en_second_int   = 1'b0;
    bus.second_dif_data = '0;
    repeat (2) @(negedge clk);
    chk("reset int_data", longint'(bus.int_data), 0);
    chk("reset busy", longint'(bus.busy), 0);
    #1 rst_n = 1'b1;

    send(100, 100, "ramp0");
    send(0, 200, "ramp1");
    send(0, 300, "ramp2");
    chk("ramp ovf", longint'(bus.ovf), 0);

    // en held across k..k+3: only the first is accepted
    @(negedge clk); #1;
    bus.en_second_int   = 1'b1;
    bus.second_dif_data = '0;
    nfin = 0;
    got  = -1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus.second_int_finish) begin nfin++; got = longint'(bus.int_data); end
      if (i == 3) begin #1 bus.en_second_int = 1'b0; end
    end
    chk("busydrop pulses", nfin, 1);
    chk("busydrop value", got, 400);

    // clr in the VEL cycle discards the in-flight sample
    @(negedge clk); #1;
    bus.en_second_int   = 1'b1;
    bus.second_dif_data = IN_W'(50);
    @(negedge clk); #1;
    bus.en_second_int = 1'b0;
    bus.clr           = 1'b1;
    @(negedge clk); #1;
    bus.clr = 1'b0;
    nfin = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.second_int_finish) nfin++;
    end
    chk("clr pulses", nfin, 0);
    chk("clr int_data", longint'(bus.int_data), 0);
    send(7, 7, "after clr");

    do_clr();
    send(500, 500, "step0");
    send(-500, 500, "step1");
    send(0, 500, "step2");
    send(0, 500, "step3");

    // asynchronous reset between k+1 and k+2
    @(negedge clk); #1;
    bus.en_second_int   = 1'b1;
    bus.second_dif_data = IN_W'(100);
    @(negedge clk); #1;
    bus.en_second_int = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst int_data", longint'(bus.int_data), 0);
    chk("arst busy", longint'(bus.busy), 0);
    chk("arst finish", longint'(bus.second_int_finish), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    send(9, 9, "after arst");

    do_clr();
    send(4000, 4000, "ovf0");
    chk("ovf clear before", longint'(bus.ovf), 0);
`ifdef SECOND_INT_SAT_EN
    send(0, 4095, "ovf1");
    send(0, 4095, "ovf2");
`else
    send(0, 3904, "ovf1");
    send(0, 3808, "ovf2");
`endif
    chk("ovf sticky", longint'(bus.ovf), 1);
    do_clr();
    chk("ovf after clr", longint'(bus.ovf), 0);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      bus.en_second_int = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) bus.second_dif_data = IN_W'($urandom);
      else                           bus.second_dif_data = IN_W'(int'($urandom_range(0, 40)) - 20);
      bus.clr = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk); #1;
    bus.en_second_int = 1'b0;
    bus.clr           = 1'b0;
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/second_int.md
# second_int

Double integrator that inverts the team's 13-bit second-difference stage: it rebuilds the original 12-bit sample stream from signed second-difference samples by running a velocity accumulator and a position accumulator in sequence. It sits on the receive/reconstruction side of the neck-check signal path, downstream of the second-difference data, with the same enable/finish pulse handshake. Starting from the zeroed state, it exactly inverts a second-difference stage that also starts zeroed.

## Interface
- DATA_W, 12, width of reconstructed unsigned sample; input is DATA_W+1 signed
- ACC_W, DATA_W+4, internal signed accumulator width (must be ≥ DATA_W+2)

- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear of accumulators, outputs and FSM; highest priority after rst_n
- en_second_int  input  1  start pulse; accepted only in WAIT
- second_dif_data  input  DATA_W+1 signed  second-difference sample, captured on the accepting edge
- int_data  output  DATA_W unsigned  reconstructed sample (registered)
- second_int_finish  output  1  one-cycle pulse, int_data valid
- busy  output  1  high whenever state ≠ WAIT
- ovf  output  1  sticky overflow/out-of-range flag

## Operation
- States are one-hot: WAIT=4'b0001, VEL=4'b0010, POS=4'b0100, FINISH=4'b1000. Any illegal state goes to WAIT.
- WAIT:
  - If en_second_int=1, then din_r <= second_dif_data and the FSM goes to VEL.
  - Otherwise the FSM stays in WAIT.
- VEL: vel_acc <= vel_acc + sext(din_r); go to POS.
- POS: pos_acc <= pos_acc + vel_acc, using the vel_acc value just updated in VEL. Then:
  - int_data <= out_map(pos_acc + vel_acc);
  - second_int_finish <= 1;
  - go to FINISH.
- FINISH: second_int_finish <= 0; go to WAIT.
- en_second_int while busy: ignored, not queued.
- Arithmetic:
  - All internal arithmetic is two's complement at ACC_W bits.
  - Accumulators wrap at ACC_W.
- ovf is set (sticky) in either case:
  - the new pos_acc is outside [0, 2^DATA_W−1];
  - the new vel_acc is outside [−2^DATA_W, 2^DATA_W−1].
- ovf is cleared only by rst_n or clr.
- clr=1 on any edge:
  - vel_acc, pos_acc, din_r, int_data and ovf go to 0;
  - second_int_finish goes to 0;
  - the FSM goes to WAIT;
  - any in-flight sample is discarded.
- clr and en_second_int in the same cycle: clr wins and the sample is dropped.
- Reset values: int_data=0, second_int_finish=0, busy=0, ovf=0, vel_acc=0, pos_acc=0, din_r=0, state=WAIT.

## Timing
- Let edge k be the edge on which en_second_int is accepted in WAIT:
  - k+1: vel_acc updated;
  - k+2: int_data and pos_acc updated, second_int_finish rises;
  - k+3: second_int_finish falls, FSM returns to WAIT.
- Latency: int_data is valid 2 edges after acceptance. second_int_finish is high for exactly one cycle.
- busy is high from after edge k until after edge k+3.
- Earliest next acceptance is edge k+4, giving a throughput of 1 sample per 4 clocks.
- second_dif_data must be stable only at the accepting edge.
- Asynchronous reset mid-operation: all outputs drop immediately to their reset values, with no finish pulse.

## Configuration
- Macro: SECOND_INT_SAT_EN.
- Defined: out_map clamps the result. Below 0 gives 0; above 2^DATA_W−1 gives 2^DATA_W−1 (4095 at the default). Accumulators still wrap internally.
- Undefined: out_map = result[DATA_W−1:0], i.e. modulo 2^DATA_W with no clamping.
- ovf behaves identically in both builds.

## Test plan
- Ramp inverse: inputs 100, 0, 0 -> int_data 100, 200, 300. Finish pulses at k+2 of each start; ovf=0.
- Step: inputs 500, −500, 0, 0 -> int_data 500, 500, 500, 500. vel_acc returns to 0 after the 2nd sample.
- Busy drop: an en pulse at k+1, k+2 and k+3 after a start -> no extra finish pulses; only one result is produced.
- Clear: clr asserted in the VEL cycle -> no finish pulse. vel_acc, pos_acc, int_data and ovf are 0. The next input 7 gives int_data=7.
- Overflow: inputs 4000, 0, 0 -> pos goes 4000, 8000 and ovf sets on the 2nd result.
  - With SECOND_INT_SAT_EN: int_data=4095.
  - Without it: int_data=8000 mod 4096=3904.
  - ovf stays high until clr.
- Reset mid-flight: drop rst_n between k+1 and k+2 -> outputs are 0 immediately and the state is WAIT after release.
